// File: rtl/pc_ir_unit_pkg.sv
// Shared CPU package: datapath width, next-PC select encodings, decoder constants.
package pc_ir_unit_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned JIDX_W = 26;

    // Next-PC select, fully decoded over two bits
    typedef enum logic [1:0] {
        PCSRC_BRANCH = 2'd0,
        PCSRC_JUMP   = 2'd1,
        PCSRC_ALU    = 2'd2,
        PCSRC_NPC    = 2'd3
    } pcsrc_e;

    // Opcode field values used by the control decoder
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type funct field values
    localparam logic [5:0] FN_JR  = 6'h08;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

endpackage

// File: rtl/pc_ir_unit_next_pc_sel.sv
// Combinational next-PC selection: branch evaluation, jump target and PCSrc mux.
module next_pc_sel
    import pc_ir_unit_pkg::*;
(
    input  logic [1:0]        pc_src,
    input  logic              pc_we,
    input  logic              ben,
    input  logic              beqbne,
    input  logic              alu_zero,
    input  logic [XLEN-1:0]   alu_result,
    input  logic [XLEN-1:0]   aluout_q,
    input  logic [XLEN-1:0]   npc_q,
    input  logic [JIDX_W-1:0] jidx,
    output logic              branch_taken,
    output logic              pc_write,
    output logic [XLEN-1:0]   next_pc
);

    logic [XLEN-1:0] jump_target;

    assign branch_taken = ben & (alu_zero ^ beqbne);
    assign pc_write     = pc_we | branch_taken;
    assign jump_target  = {npc_q[XLEN-1:XLEN-4], jidx, 2'b00};

    // A taken branch overrides PCSrc and always targets the latched branch address
    always_comb begin
        next_pc = aluout_q;
        if (!branch_taken) begin
            case (pc_src)
                PCSRC_BRANCH: next_pc = aluout_q;
                PCSRC_JUMP:   next_pc = jump_target;
                PCSRC_ALU:    next_pc = alu_result;
                PCSRC_NPC:    next_pc = npc_q;
                default:      next_pc = aluout_q;
            endcase
        end
    end

endmodule

// File: rtl/pc_ir_unit.sv
// Multicycle CPU fetch state: PC, IR, latched PC+4, ALU output register and fetch counter.
module pc_ir_unit
    import pc_ir_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            PC_WE,
    input  logic            IR_WE,
    input  logic [1:0]      PCSrc,
    input  logic            BEN,
    input  logic            BEQBNE,
    input  logic            MemIn,
    input  logic [XLEN-1:0] alu_result,
    input  logic            alu_zero,
    input  logic [XLEN-1:0] mem_rdata,
    output logic [XLEN-1:0] instruction,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] npc,
    output logic [XLEN-1:0] aluout,
    output logic [XLEN-1:0] mem_addr,
    output logic            branch_taken,
    output logic [XLEN-1:0] instr_count
);

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] ir_q;
    logic [XLEN-1:0] npc_q;
    logic [XLEN-1:0] aluout_q;
    logic [XLEN-1:0] instr_count_q;
    logic [XLEN-1:0] next_pc;
    logic            pc_write;

    next_pc_sel u_next_pc_sel (
        .pc_src       (PCSrc),
        .pc_we        (PC_WE),
        .ben          (BEN),
        .beqbne       (BEQBNE),
        .alu_zero     (alu_zero),
        .alu_result   (alu_result),
        .aluout_q     (aluout_q),
        .npc_q        (npc_q),
        .jidx         (ir_q[JIDX_W-1:0]),
        .branch_taken (branch_taken),
        .pc_write     (pc_write),
        .next_pc      (next_pc)
    );

    // Fetch-side registers; reset wins over every enable
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q          <= RESET_PC;
            ir_q          <= '0;
            npc_q         <= XLEN'(RESET_PC + 32'd4);
            aluout_q      <= '0;
            instr_count_q <= '0;
        end else begin
            aluout_q <= alu_result;
            if (IR_WE) begin
                ir_q          <= mem_rdata;
                npc_q         <= XLEN'(pc_q + 32'd4);
                instr_count_q <= XLEN'(instr_count_q + 32'd1);
            end
            if (pc_write) begin
                pc_q <= {next_pc[XLEN-1:2], 2'b00};
            end
        end
    end

    assign instruction = ir_q;
    assign pc          = pc_q;
    assign npc         = npc_q;
    assign aluout      = aluout_q;
    assign instr_count = instr_count_q;
    assign mem_addr    = MemIn ? aluout_q : pc_q;

endmodule
